// File: rtl/tt_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper.
// Holds the state encoding, the truth-table width and the settle-timer width function.
package tt_pkg;

    localparam int TT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } tt_state_e;

    // Never returns zero, so SETTLE=0 still gets a legal 1-bit counter.
    function automatic int timer_w(input int settle);
        if (settle < 2) begin
            return 1;
        end
        return $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Per-vector hold timer: counts 0..SETTLE, then wraps to 0.
// o_expired is high while the count equals SETTLE, so SETTLE=0 expires on every cycle.
module tt_settle_timer
    import tt_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);

    localparam int TIMER_W = timer_w(SETTLE);

    logic [TIMER_W-1:0] r_timer;

    assign o_expired = (r_timer == TIMER_W'(SETTLE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
        end else if (i_load) begin
            r_timer <= '0;
        end else if (i_en) begin
            if (o_expired) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TIMER_W'(1);
            end
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector into a 4-input gate under test and packs the sampled outputs
// into a library-style truth-table code, then compares that code with an expected value.
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [TT_W-1:0]  expected_tt,
    output logic [N_IN-1:0]  dut_in,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic [TT_W-1:0]  result,
    output logic             match,
    output logic [1:0]       dbg_state
);

    // Handshake: start is taken only in IDLE (no queuing). busy rises on the next edge and
    // stays high through RUN. done is a one-cycle pulse, coincident with busy falling, when
    // result/match update; both then hold until the next completed sweep.

    tt_state_e         r_state;
    logic [N_IN-1:0]   r_idx;
    logic [N_IN-1:0]   r_dut_in;
    logic [TT_W-1:0]   r_shreg;
    logic [TT_W-1:0]   r_exp;
    logic [TT_W-1:0]   r_result;
    logic              r_match;
    logic              r_done;
    logic              r_busy;

    logic              w_accept;
    logic              w_run;
    logic              w_expired;
    logic              w_last;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_run    = (r_state == ST_RUN);
    assign w_last   = (r_idx == {N_IN{1'b1}});

    tt_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_accept),
        .i_en      (w_run),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_dut_in <= '0;
            r_shreg  <= '0;
            r_exp    <= '0;
            r_result <= '0;
            r_match  <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_exp    <= expected_tt;
                        r_idx    <= '0;
                        r_dut_in <= '0;
                        r_shreg  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_expired) begin
                        // Vector i lands at result[15-i] once all 16 samples are in.
                        r_shreg <= {r_shreg[TT_W-2:0], dut_out};
                        if (w_last) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_idx    <= r_idx + N_IN'(1);
                            r_dut_in <= r_idx + N_IN'(1);
                        end
                    end
                end
                ST_DONE: begin
                    r_result <= r_shreg;
                    r_match  <= (r_shreg == r_exp);
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_dut_in <= '0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dut_in    = r_dut_in;
    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign match     = r_match;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: one instance with SETTLE=2 and one with SETTLE=0,
// each driving a behavioural gate under test selected by gut_mode/gut_code.
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_x;
    logic        sel;
    logic [15:0] exp_x;
    logic [15:0] gut_code;
    int          gut_mode;

    logic        start_a, start_b;
    logic [3:0]  din_a, din_b;
    logic        dout_a, dout_b;
    logic        busy_a, busy_b, done_a, done_b, match_a, match_b;
    logic [15:0] res_a, res_b;
    logic [1:0]  st_a, st_b;

    logic        x_busy, x_done, x_match;
    logic [3:0]  x_din;
    logic [15:0] x_res;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    // Gate under test. Inputs _0.._3 come from dut_in[3]..dut_in[0], so vector i = {_0,_1,_2,_3}.
    // mode 0: library-code gate (output for vector i is code bit 15-i); 1: tied high; 2: output = _0.
    function automatic logic gut_eval(input int mode, input logic [15:0] code, input logic [3:0] v);
        case (mode)
            0:       return code[4'd15 - v];
            1:       return 1'b1;
            2:       return v[3];
            default: return 1'b0;
        endcase
    endfunction

    // Reference code: bit (15-i) of the truth-table word is the gate output for vector i.
    function automatic logic [15:0] model_tt(input int mode, input logic [15:0] code);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[15 - i] = gut_eval(mode, code, 4'(i));
        end
        return r;
    endfunction

    assign dout_a  = gut_eval(gut_mode, gut_code, din_a);
    assign dout_b  = gut_eval(gut_mode, gut_code, din_b);
    assign start_a = start_x & ~sel;
    assign start_b = start_x & sel;
    assign x_busy  = sel ? busy_b  : busy_a;
    assign x_done  = sel ? done_b  : done_a;
    assign x_match = sel ? match_b : match_a;
    assign x_din   = sel ? din_b   : din_a;
    assign x_res   = sel ? res_b   : res_a;

    truth_table_sweeper #(.N_IN(4), .SETTLE(2)) u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .start       (start_a),
        .expected_tt (exp_x),
        .dut_in      (din_a),
        .dut_out     (dout_a),
        .busy        (busy_a),
        .done        (done_a),
        .result      (res_a),
        .match       (match_a),
        .dbg_state   (st_a)
    );

    truth_table_sweeper #(.N_IN(4), .SETTLE(0)) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .start       (start_b),
        .expected_tt (exp_x),
        .dut_in      (din_b),
        .dut_out     (dout_b),
        .busy        (busy_b),
        .done        (done_b),
        .result      (res_b),
        .match       (match_b),
        .dbg_state   (st_b)
    );

    task automatic test_reset();
        rst = 1'b1; start_x = 1'b0; sel = 1'b0; exp_x = '0; gut_mode = 0; gut_code = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({din_a, busy_a, done_a, res_a, match_a, st_a} !== 25'd0) begin
            $display("FAIL reset_a: got din=%h busy=%b done=%b res=%h match=%b st=%h want all 0",
                     din_a, busy_a, done_a, res_a, match_a, st_a);
        end else passed++;
        checks++;
        if ({din_b, busy_b, done_b, res_b, match_b, st_b} !== 25'd0) begin
            $display("FAIL reset_b: got din=%h busy=%b done=%b res=%h match=%b st=%h want all 0",
                     din_b, busy_b, done_b, res_b, match_b, st_b);
        end else passed++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({din_a, busy_a, done_a, din_b, busy_b, done_b} !== 10'd0) begin
            $display("FAIL idle_after_reset: got din_a=%h busy_a=%b done_a=%b din_b=%h busy_b=%b done_b=%b want 0",
                     din_a, busy_a, done_a, din_b, busy_b, done_b);
        end else passed++;
    endtask

    // One full sweep on the selected instance with latency, sequence and result checks.
    task automatic do_sweep(input logic s, input int mode, input logic [15:0] code,
                            input logic [15:0] exp, input logic [15:0] want,
                            input bit flip_exp, input string name);
        int settle, lat, j, dinerr, busyerr;
        logic [3:0] ed;
        settle = s ? 0 : 2;
        lat = 16 * (settle + 1) + 1;
        sel = s; gut_mode = mode; gut_code = code;
        @(negedge clk);
        exp_x = exp; start_x = 1'b1;
        @(negedge clk);
        start_x = 1'b0;
        j = 0; dinerr = 0; busyerr = 0;
        while (x_done !== 1'b1 && j < lat + 20) begin
            ed = (j / (settle + 1) > 15) ? 4'd15 : 4'(j / (settle + 1));
            if (x_din !== ed) dinerr++;
            if (x_busy !== 1'b1) busyerr++;
            if (flip_exp && j == 5) exp_x = ~exp;
            @(negedge clk);
            j++;
        end
        checks++;
        if (j !== lat) $display("FAIL %s latency: got %0d cycles want %0d", name, j, lat);
        else passed++;
        checks++;
        if (x_res !== want) $display("FAIL %s result: got %h want %h", name, x_res, want);
        else passed++;
        checks++;
        if (x_match !== (want == exp)) $display("FAIL %s match: got %b want %b", name, x_match, want == exp);
        else passed++;
        checks++;
        if (dinerr != 0) $display("FAIL %s dut_in_seq: got %0d bad cycles want 0", name, dinerr);
        else passed++;
        checks++;
        if (busyerr != 0) $display("FAIL %s busy_during: got %0d low cycles want 0", name, busyerr);
        else passed++;
        checks++;
        if ({x_busy, x_din} !== 5'd0) $display("FAIL %s at_done: got busy=%b din=%h want 0 0", name, x_busy, x_din);
        else passed++;
        @(negedge clk);
        checks++;
        if (x_done !== 1'b0 || x_res !== want)
            $display("FAIL %s done_pulse_hold: got done=%b res=%h want 0 %h", name, x_done, x_res, want);
        else passed++;
        exp_x = '0;
    endtask

    task automatic test_main();
        do_sweep(1'b0, 0, 16'h9BF5, 16'h9BF5, 16'h9BF5, 1'b0, "gate9bf5_match");
        do_sweep(1'b0, 0, 16'h9BF5, 16'hAFD9, 16'h9BF5, 1'b0, "gate9bf5_reversed");
    endtask

    task automatic test_settle0();
        do_sweep(1'b1, 1, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0, "tied1_settle0");
        do_sweep(1'b1, 2, 16'h0000, 16'h1234, 16'h00FF, 1'b0, "in0_settle0");
    endtask

    task automatic test_mid_reset();
        int bad_done, bad_busy;
        sel = 1'b0; gut_mode = 0; gut_code = 16'h5A3C; exp_x = 16'h5A3C;
        @(negedge clk);
        start_x = 1'b1;
        @(negedge clk);
        start_x = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({din_a, busy_a, done_a, res_a, match_a, st_a} !== 25'd0) begin
            $display("FAIL mid_reset_clear: got din=%h busy=%b done=%b res=%h match=%b st=%h want all 0",
                     din_a, busy_a, done_a, res_a, match_a, st_a);
        end else passed++;
        @(negedge clk);
        rst = 1'b0;
        bad_done = 0; bad_busy = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done_a !== 1'b0) bad_done++;
            if (busy_a !== 1'b0) bad_busy++;
        end
        checks++;
        if (bad_done != 0 || bad_busy != 0)
            $display("FAIL mid_reset_quiet: got done_cycles=%0d busy_cycles=%0d want 0 0", bad_done, bad_busy);
        else passed++;
        do_sweep(1'b0, 0, 16'h5A3C, 16'h5A3C, model_tt(0, 16'h5A3C), 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        int done_q[$];
        int badres, k;
        logic [15:0] code;
        code = 16'($urandom);
        sel = 1'b0; gut_mode = 0; gut_code = code; exp_x = code;
        badres = 0;
        @(negedge clk);
        start_x = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 160; j++) begin
            if (done_a === 1'b1) begin
                done_q.push_back(j);
                if (res_a !== model_tt(0, code) || match_a !== 1'b1) badres++;
            end
            @(negedge clk);
        end
        start_x = 1'b0;
        checks++;
        if (done_q.size() != 3) $display("FAIL b2b_count: got %0d dones want 3", done_q.size());
        else passed++;
        foreach (done_q[i]) begin
            checks++;
            if (done_q[i] != 49 + 50 * i) $display("FAIL b2b_spacing: got done at %0d want %0d", done_q[i], 49 + 50 * i);
            else passed++;
        end
        checks++;
        if (badres != 0) $display("FAIL b2b_result: got %0d bad results want 0", badres);
        else passed++;
        k = 0;
        while (busy_a === 1'b1 && k < 120) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b0) $display("FAIL b2b_drain: got busy=%b want 0", busy_a);
        else passed++;
    endtask

    task automatic test_ignored_start();
        int j, extra;
        logic [15:0] code;
        code = 16'($urandom);
        sel = 1'b0; gut_mode = 0; gut_code = code; exp_x = ~code;
        @(negedge clk);
        start_x = 1'b1;
        @(negedge clk);
        j = 0;
        while (done_a !== 1'b1 && j < 80) begin
            // Random pulses while busy, then start held into the DONE cycle.
            if (j < 48) start_x = 1'($urandom_range(0, 1));
            else start_x = (j == 48);
            @(negedge clk);
            j++;
        end
        start_x = 1'b0;
        checks++;
        if (j != 49) $display("FAIL ignored_latency: got %0d want 49", j);
        else passed++;
        checks++;
        if (res_a !== model_tt(0, code) || match_a !== 1'b0)
            $display("FAIL ignored_result: got %h/%b want %h/0", res_a, match_a, model_tt(0, code));
        else passed++;
        extra = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done_a !== 1'b0 || busy_a !== 1'b0) extra++;
        end
        checks++;
        if (extra != 0) $display("FAIL ignored_no_extra: got %0d active cycles want 0", extra);
        else passed++;
    endtask

    task automatic test_random();
        logic s;
        logic [15:0] code, exp;
        for (int n = 0; n < 6; n++) begin
            s = 1'($urandom_range(0, 1));
            code = 16'($urandom);
            exp = ($urandom_range(0, 1) == 1) ? code : 16'($urandom);
            do_sweep(s, 0, code, exp, model_tt(0, code), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_main();
        test_settle0();
        test_mid_reset();
        test_back_to_back();
        test_ignored_start();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish want finish before 500000");
        $fatal(1, "timeout");
    end

endmodule
